// File: rtl/cross_bar_pkg.sv
// rtl/cross_bar_pkg.sv - shared types and constants for the cross-bar slave arbiter
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int MASTER_W = $clog2(MASTER_N);
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  typedef logic [MASTER_W-1:0] master_id_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cross_bar_rr_picker.sv
// rtl/cross_bar_rr_picker.sv - combinational round-robin pick: first eligible requester after the pointer
module cross_bar_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic [N-1:0] excl_i,
  output logic         valid_o,
  output logic [W-1:0] winner_o
);

  // Scan from farthest to nearest so the requester closest after the pointer wins.
  always_comb begin
    int idx;
    idx      = 0;
    valid_o  = 1'b0;
    winner_o = '0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(ptr_i) + off) % N;
      if (req_i[idx] && !excl_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = W'(idx);
      end
    end
  end

endmodule

// File: rtl/cross_bar_slave_arbiter.sv
// rtl/cross_bar_slave_arbiter.sv - round-robin sharing of one slave port between masters
// CROSS_BAR_ARB_TIMEOUT_EN adds an ACCESS timeout that completes the transfer with master_err.
module cross_bar_slave_arbiter
  import cross_bar_pkg::ADDR_W, cross_bar_pkg::DATA_W;
#(
  parameter int   MASTER_N       = 4,
  parameter int   TIMEOUT_CYCLES = 64,
  localparam int  MW             = $clog2(MASTER_N)
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [MASTER_N-1:0]        master_req,
  input  logic [MASTER_N*ADDR_W-1:0] master_addr,
  input  logic [MASTER_N-1:0]        master_cmd,
  input  logic [MASTER_N*DATA_W-1:0] master_wdata,
  output logic [MASTER_N-1:0]        master_ack,
  output logic [DATA_W-1:0]          master_rdata,
  output logic [MASTER_N-1:0]        master_err,
  output logic                       slave_req,
  output logic [ADDR_W-1:0]          slave_addr,
  output logic                       slave_cmd,
  output logic [DATA_W-1:0]          slave_wdata,
  input  logic                       slave_ack,
  input  logic [DATA_W-1:0]          slave_rdata,
  output logic [MW-1:0]              grant_id
);

  import cross_bar_pkg::arb_state_t;
  import cross_bar_pkg::IDLE;
  import cross_bar_pkg::ACCESS;
  import cross_bar_pkg::DONE;
  import cross_bar_pkg::addr_t;
  import cross_bar_pkg::data_t;

  if (MASTER_N < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cross_bar_slave_arbiter: MASTER_N must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t    state_q, state_d;
  logic [MW-1:0] ptr_q, ptr_d;
  logic [MW-1:0] grant_q, grant_d;
  addr_t         addr_q, addr_d;
  logic          cmd_q, cmd_d;
  data_t         wdata_q, wdata_d;
  data_t         rdata_q, rdata_d;

  logic [MASTER_N-1:0] grant_oh;
  logic [MASTER_N-1:0] excl;
  logic                pick_valid;
  logic [MW-1:0]       pick_id;

  assign grant_oh = {{(MASTER_N-1){1'b0}}, 1'b1} << grant_q;
  // The master just acknowledged may still hold req for this cycle; it must not win again.
  assign excl     = (state_q == DONE) ? grant_oh : '0;

  cross_bar_rr_picker #(
    .N (MASTER_N),
    .W (MW)
  ) u_picker (
    .req_i    (master_req),
    .ptr_i    (ptr_q),
    .excl_i   (excl),
    .valid_o  (pick_valid),
    .winner_o (pick_id)
  );

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (pick_valid) begin
          state_d = ACCESS;
          ptr_d   = pick_id;
          grant_d = pick_id;
          addr_d  = master_addr[int'(pick_id)*ADDR_W +: ADDR_W];
          cmd_d   = master_cmd[pick_id];
          wdata_d = master_wdata[int'(pick_id)*DATA_W +: DATA_W];
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ACCESS: begin
        if (slave_ack) begin
          state_d = DONE;
          rdata_d = cmd_q ? '0 : slave_rdata;
        end
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= MW'(MASTER_N - 1);
      grant_q <= '0;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign slave_req    = (state_q == ACCESS);
  assign slave_addr   = addr_q;
  assign slave_cmd    = cmd_q;
  assign slave_wdata  = wdata_q;
  assign master_ack   = (state_q == DONE) ? grant_oh : '0;
  assign master_rdata = rdata_q;
  assign grant_id     = grant_q;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  assign master_err   = (state_q == DONE && err_q) ? grant_oh : '0;
`else
  assign master_err   = '0;
`endif

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// tb/tb_cross_bar_slave_arbiter.sv - self-checking bench for cross_bar_slave_arbiter with an in-bench slave
module tb_cross_bar_slave_arbiter;

  localparam int N = 4;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic aresetn;
  logic [N-1:0] m_req, m_cmd;
  logic [31:0] m_addr [N];
  logic [31:0] m_wdata [N];
  logic [N*32-1:0] addr_flat, wdata_flat;
  logic [N-1:0] master_ack, master_err;
  logic [31:0] master_rdata, slave_addr, slave_wdata, slave_rdata;
  logic slave_req, slave_cmd, vip_ack, stall;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_flat[i*32 +: 32]  = m_addr[i];
      wdata_flat[i*32 +: 32] = m_wdata[i];
    end
  end

  cross_bar_slave_arbiter #(.MASTER_N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .aresetn(aresetn),
    .master_req(m_req), .master_addr(addr_flat), .master_cmd(m_cmd), .master_wdata(wdata_flat),
    .master_ack(master_ack), .master_rdata(master_rdata), .master_err(master_err),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd), .slave_wdata(slave_wdata),
    .slave_ack(vip_ack), .slave_rdata(slave_rdata), .grant_id(grant_id)
  );

  // slave: registered ack held while req is high, word memory indexed by addr[9:2]
  logic [31:0] vip_mem [256];
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vip_ack <= 1'b0;
      for (int i = 0; i < 256; i++) vip_mem[i] <= '0;
    end else begin
      vip_ack <= slave_req && !stall;
      if (slave_req && slave_cmd && !vip_ack) vip_mem[slave_addr[9:2]] <= slave_wdata;
    end
  end
  assign slave_rdata = vip_mem[slave_addr[9:2]];

  int n_pass = 0, n_chk = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // transaction-level model: who must be served next, what the slave must see, what returns
  bit          e_req;
  int          e_ack, e_grant, last, cnt;
  bit          e_err, e_cmd;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [31:0] mmem [256];
  logic [N-1:0] ack_log[$];
  int           ack_cyc[$];

  always @(negedge clk) begin
    if (!aresetn) begin
      e_req = 0; e_ack = -1; e_grant = 0; last = N - 1; e_err = 0; e_rdata = '0; cnt = 0;
      for (int i = 0; i < 256; i++) mmem[i] = '0;
      chk("rst_slave_req", slave_req, 0);
      chk("rst_master_ack", master_ack, 0);
    end else begin
      chk("slave_req", slave_req, e_req);
      chk("master_ack", master_ack, (e_ack >= 0) ? (64'd1 << e_ack) : 64'd0);
      chk("master_err", master_err, (e_ack >= 0 && e_err) ? (64'd1 << e_ack) : 64'd0);
      chk("master_rdata", master_rdata, e_rdata);
      chk("grant_id", grant_id, e_grant);
      if (e_req) begin
        chk("slave_addr", slave_addr, e_addr);
        chk("slave_cmd", slave_cmd, e_cmd);
        chk("slave_wdata", slave_wdata, e_wdata);
      end
      if (master_ack != 0) begin
        ack_log.push_back(master_ack);
        ack_cyc.push_back(cyc);
      end
      if (e_req) begin
        if (vip_ack) begin
          e_req = 0; e_ack = e_grant; e_err = 0;
          if (e_cmd) begin
            mmem[e_addr[9:2]] = e_wdata;
            e_rdata = '0;
          end else e_rdata = mmem[e_addr[9:2]];
        end
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        else begin
          cnt++;
          if (cnt == TO) begin
            e_req = 0; e_ack = e_grant; e_err = 1; e_rdata = '0;
          end
        end
`endif
      end else begin
        int ex, w;
        ex = e_ack; e_ack = -1; w = -1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (last + k) % N;
          if (w < 0 && m_req[c] && c != ex) w = c;
        end
        if (w >= 0) begin
          e_req = 1; e_grant = w; last = w; cnt = 0;
          e_addr = m_addr[w]; e_cmd = m_cmd[w]; e_wdata = m_wdata[w];
        end
      end
    end
  end

  task automatic drive(input int i, input logic [31:0] a, input logic c, input logic [31:0] d);
    m_addr[i] = a; m_cmd[i] = c; m_wdata[i] = d; m_req[i] = 1'b1;
  endtask

  task automatic wait_ack(input int i, input int budget, output int lat);
    int start;
    bit got;
    start = cyc; got = 0; lat = -1;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (master_ack[i]) got = 1;
    end
    chk($sformatf("ack_seen_m%0d", i), got, 1);
    if (got) lat = cyc - start;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int k = 0; k < budget && ack_log.size() < n; k++) @(negedge clk);
    chk("ack_log_count", ack_log.size() >= n, 1);
  endtask

  task automatic do_reset(input logic [N-1:0] req_during);
    @(posedge clk); #1;
    aresetn = 0; m_req = req_during; stall = 0;
    ack_log.delete(); ack_cyc.delete();
    repeat (2) @(posedge clk);
    #1 aresetn = 1;
  endtask

  int lat;
  bit saw_req;
  logic [N-1:0] exp_seq [5];

  initial begin
    aresetn = 0; m_req = '0; m_cmd = '0; stall = 0;
    for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_wdata[i] = '0; end
    repeat (2) @(negedge clk);
    chk("lit_rst_grant_id", grant_id, 0);
    chk("lit_rst_rdata", master_rdata, 0);
    chk("lit_rst_slave_addr", slave_addr, 0);
    @(posedge clk); #1 aresetn = 1;

    // single write then read from M0
    @(posedge clk); #1 drive(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    wait_ack(0, 20, lat);
    chk("lit_write_latency", lat, 3);
    @(posedge clk); #1 m_req[0] = 0;
    chk("lit_slave_saw_write", vip_mem[4], 32'hDEAD_BEEF);
    @(posedge clk); #1 drive(0, 32'h0000_0010, 1'b0, 32'h0);
    wait_ack(0, 20, lat);
    chk("lit_read_latency", lat, 3);
    chk("lit_read_rdata", master_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 m_req[0] = 0;

    // M3 drops req while granted; transfer still completes
    @(posedge clk); #1 drive(3, 32'h0000_0020, 1'b1, 32'h1234_5678);
    for (int k = 0; k < 10 && !slave_req; k++) @(negedge clk);
    chk("lit_m3_granted", slave_req, 1);
    @(posedge clk); #1 m_req[3] = 0;
    wait_ack(3, 20, lat);

    // idle for 100 cycles
    saw_req = 0;
    repeat (100) begin
      @(negedge clk);
      if (slave_req) saw_req = 1;
    end
    chk("lit_idle_no_slave_req", saw_req, 0);
    chk("lit_idle_grant_id", grant_id, 3);

    // all four masters held from reset
    for (int i = 0; i < N; i++) begin
      m_addr[i] = 32'h100 + 32'(i * 4); m_cmd[i] = 1'b1; m_wdata[i] = 32'h1111_1111 * 32'(i + 1);
    end
    do_reset(4'hF);
    wait_log(5, 40);
    m_req = '0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int k = 0; k < 5 && k < ack_log.size(); k++) chk("lit_rr4_order", ack_log[k], exp_seq[k]);
    for (int k = 1; k < 5 && k < ack_cyc.size(); k++) chk("lit_rr4_spacing", ack_cyc[k] - ack_cyc[k-1], 3);

    // M1 and M2 continuous
    do_reset(4'b0110);
    wait_log(4, 30);
    m_req = '0;
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0100;
    for (int k = 0; k < 4 && k < ack_log.size(); k++) chk("lit_rr2_order", ack_log[k], exp_seq[k]);

    // reset in ACCESS
    do_reset('0);
    @(posedge clk); #1 drive(2, 32'h0000_0040, 1'b0, 32'h0);
    for (int k = 0; k < 10 && !slave_req; k++) @(negedge clk);
    chk("lit_m2_in_access", slave_req, 1);
    #1 aresetn = 0;
    #1 chk("lit_async_slave_req_drop", slave_req, 0);
    m_req = 4'b1001; m_cmd[0] = 1'b0; m_cmd[3] = 1'b0;
    ack_log.delete(); ack_cyc.delete();
    repeat (3) @(negedge clk);
    chk("lit_no_ack_in_reset", ack_log.size(), 0);
    @(posedge clk); #1 aresetn = 1;
    wait_log(1, 20);
    if (ack_log.size() > 0) chk("lit_first_grant_after_reset", ack_log[0], 4'b0001);
    @(posedge clk); #1 m_req = '0;
    repeat (4) @(posedge clk);

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    do_reset('0);
    @(posedge clk); #1 drive(1, 32'h0000_0030, 1'b1, 32'h0000_CAFE);
    wait_ack(1, 20, lat);
    @(posedge clk); #1 m_cmd[1] = 1'b0;
    wait_ack(1, 20, lat);
    chk("lit_to_pre_read", master_rdata, 32'h0000_CAFE);
    @(posedge clk); #1 m_req[1] = 0; stall = 1;
    @(posedge clk); #1 drive(1, 32'h0000_0030, 1'b0, 32'h0);
    wait_ack(1, 40, lat);
    chk("lit_to_latency", lat, TO + 1);
    chk("lit_to_err", master_err, 4'b0010);
    chk("lit_to_rdata", master_rdata, 32'h0);
    @(posedge clk); #1 m_req[1] = 0; stall = 0;
    repeat (4) @(posedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
